// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and default sizing for the FIFO control blocks
package fifo_pkg;
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fifo_state_e;
    localparam int ADDR_W_DEF       = 4;
    localparam int AFULL_THRESH_DEF = 12;
endpackage

// File: rtl/fifo_occ_counter.sv
// fifo_occ_counter: up/down occupancy counter with clear and registered level flags
module fifo_occ_counter
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rest_n,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_clr,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_afull,
    output logic              o_empty
);
    localparam int DEPTH = 1 << ADDR_W;
    logic            dec_v;
    logic [ADDR_W:0] cnt_nxt;
    // a decrement at zero is dropped here; the caller flags it as underflow
    always_comb begin
        dec_v   = i_dec & (o_count != '0);
        cnt_nxt = i_clr             ? '0 :
                  (i_inc & ~dec_v)  ? o_count + 1'b1 :
                  (dec_v & ~i_inc)  ? o_count - 1'b1 : o_count;
    end
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            o_count <= '0;
            o_full  <= 1'b0;
            o_afull <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            o_count <= cnt_nxt;
            o_full  <= cnt_nxt == (ADDR_W+1)'(DEPTH);
            o_afull <= cnt_nxt >= (ADDR_W+1)'(AFULL_THRESH);
            o_empty <= cnt_nxt == '0;
        end
    end
endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side FIFO control - write qualification, write pointer,
// occupancy tracking, flush sequencing and sticky overflow/underflow flags
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rest_n,
    input  logic              i_wen,
    input  logic              i_rd_done,
    input  logic              i_flush,
    output logic              o_wen_ctrl,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_afull,
    output logic              o_empty,
    output logic              o_ovf,
    output logic              o_udf
);
    fifo_state_e state;
    logic        run;
    logic        flush_in;
    always_comb begin
        run        = state == ST_RUN;
        flush_in   = run & i_flush;
        o_wen_ctrl = i_wen & ~o_full & run;
    end
    // entering FLUSH wipes pointer, occupancy and errors in one edge
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            state   <= ST_INIT;
            o_waddr <= '0;
            o_ovf   <= 1'b0;
            o_udf   <= 1'b0;
        end else begin
            state   <= (state == ST_INIT)              ? ST_RUN :
                       flush_in                        ? ST_FLUSH :
                       (state == ST_FLUSH && !i_flush) ? ST_RUN : state;
            o_waddr <= flush_in ? '0 : o_waddr + ADDR_W'(o_wen_ctrl);
            o_ovf   <= flush_in ? 1'b0 : o_ovf | (run & i_wen & o_full);
            o_udf   <= flush_in ? 1'b0 : o_udf | (run & i_rd_done & (o_count == '0));
        end
    end
    fifo_occ_counter #(
        .ADDR_W       (ADDR_W),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_occ (
        .i_clk    (i_clk),
        .i_rest_n (i_rest_n),
        .i_inc    (o_wen_ctrl),
        .i_dec    (run & i_rd_done),
        .i_clr    (flush_in),
        .o_count  (o_count),
        .o_full   (o_full),
        .o_afull  (o_afull),
        .o_empty  (o_empty)
    );
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: directed self-checking bench for fifo_write_ctrl
module tb_fifo_write_ctrl;
    logic       i_clk;
    logic       i_rest_n;
    logic       i_wen;
    logic       i_rd_done;
    logic       i_flush;
    logic       o_wen_ctrl;
    logic [3:0] o_waddr;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_afull;
    logic       o_empty;
    logic       o_ovf;
    logic       o_udf;
    int         checks;
    int         failures;

    fifo_write_ctrl #(.ADDR_W(4), .AFULL_THRESH(12)) dut (
        .i_clk      (i_clk),
        .i_rest_n   (i_rest_n),
        .i_wen      (i_wen),
        .i_rd_done  (i_rd_done),
        .i_flush    (i_flush),
        .o_wen_ctrl (o_wen_ctrl),
        .o_waddr    (o_waddr),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_afull    (o_afull),
        .o_empty    (o_empty),
        .o_ovf      (o_ovf),
        .o_udf      (o_udf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        i_rest_n  = 1'b0;
        i_wen     = 1'b1;
        i_rd_done = 1'b0;
        i_flush   = 1'b0;
        cyc(2);
        chk("rst_count", o_count, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_afull", o_afull, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_udf", o_udf, 0);
        chk("rst_wen_ctrl", o_wen_ctrl, 0);
        i_rest_n = 1'b1;
        #1 chk("init_wen_ctrl", o_wen_ctrl, 0);
        cyc(1);
        chk("run_wen_ctrl", o_wen_ctrl, 1);
        chk("run_count0", o_count, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            if (k == 1) chk("empty_after_1", o_empty, 0);
            if (k == 11) chk("afull_at_11", o_afull, 0);
            if (k == 12) chk("afull_at_12", o_afull, 1);
            if (k == 15) chk("full_at_15", o_full, 0);
        end
        chk("fill_count", o_count, 16);
        chk("fill_full", o_full, 1);
        chk("fill_waddr_wrap", o_waddr, 0);
        chk("fill_wen_ctrl", o_wen_ctrl, 0);
        chk("fill_ovf_pre", o_ovf, 0);
        i_rd_done = 1'b1;
        #1 chk("full_rd_wen_ctrl", o_wen_ctrl, 0);
        cyc(1);
        chk("full_rd_count", o_count, 15);
        chk("full_rd_full", o_full, 0);
        chk("full_rd_ovf", o_ovf, 1);
        chk("full_rd_waddr", o_waddr, 0);
        i_wen = 1'b0;
        cyc(6);
        chk("drain_count9", o_count, 9);
        chk("drain_afull", o_afull, 0);
        i_flush = 1'b1;
        i_wen   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("flush_wen_ctrl", o_wen_ctrl, 0);
            chk("flush_count", o_count, 0);
            chk("flush_waddr", o_waddr, 0);
            chk("flush_ovf", o_ovf, 0);
            chk("flush_udf", o_udf, 0);
            chk("flush_empty", o_empty, 1);
        end
        i_flush   = 1'b0;
        i_rd_done = 1'b0;
        #1 chk("flush_fall_wen_ctrl", o_wen_ctrl, 0);
        cyc(1);
        chk("post_flush_wen_ctrl", o_wen_ctrl, 1);
        cyc(1);
        chk("post_flush_count", o_count, 1);
        chk("post_flush_waddr", o_waddr, 1);
        cyc(4);
        chk("mix_start_count", o_count, 5);
        i_rd_done = 1'b1;
        cyc(10);
        chk("mix_count", o_count, 5);
        chk("mix_waddr", o_waddr, 15);
        chk("mix_ovf", o_ovf, 0);
        chk("mix_udf", o_udf, 0);
        i_wen = 1'b0;
        cyc(5);
        chk("empty_count", o_count, 0);
        chk("empty_flag", o_empty, 1);
        chk("empty_udf_pre", o_udf, 0);
        cyc(1);
        chk("udf_count", o_count, 0);
        chk("udf_empty", o_empty, 1);
        chk("udf_set", o_udf, 1);
        i_rd_done = 1'b0;
        i_wen     = 1'b1;
        cyc(7);
        chk("pre_rst_count", o_count, 7);
        i_wen = 1'b0;
        #2 i_rest_n = 1'b0;
        #1;
        chk("async_rst_count", o_count, 0);
        chk("async_rst_waddr", o_waddr, 0);
        chk("async_rst_empty", o_empty, 1);
        chk("async_rst_udf", o_udf, 0);
        chk("async_rst_full", o_full, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
